// File: rtl/stage7_norm_div_pkg.sv
// stage_pkg: shared state encoding and default widths for the normalisation stage.
package stage_pkg;
    localparam int AW_D = 16;
    localparam int BW_D = 8;
    localparam int QW_D = 8;
    localparam int PIX_MAX = (1 << QW_D) - 1;
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
endpackage

// File: rtl/stage7_norm_div_if.sv
// stage7_norm_div_if: input and output valid/ready channels of the normalisation stage.
interface stage7_norm_div_if
    import stage_pkg::*;
#(
    parameter int AW = AW_D,
    parameter int BW = BW_D,
    parameter int QW = QW_D
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] pix;
    logic          sat;
    logic          div_zero;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, pix, sat, div_zero);
    modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, pix, sat, div_zero);
endinterface

// File: rtl/stage7_norm_div_div_step.sv
// div_step: one combinational restoring-division step; r < b on entry keeps r_nx < b.
module div_step #(
    parameter int BW = 8
) (
    input  logic [BW-1:0] r,
    input  logic          din,
    input  logic [BW-1:0] b,
    output logic [BW-1:0] r_nx,
    output logic          qb
);
    logic [BW:0] t;
    always_comb begin
        t    = {r, din};
        qb   = t >= {1'b0, b};
        r_nx = qb ? BW'(t - {1'b0, b}) : t[BW-1:0];
    end
endmodule

// File: rtl/stage7_norm_div.sv
// stage7_norm_div: rounded, saturated a/b via an iterative restoring divider.
module stage7_norm_div
    import stage_pkg::*;
#(
    parameter int AW = AW_D,
    parameter int BW = BW_D,
    parameter int QW = QW_D
) (
    input logic clk,
    input logic rst,
    stage7_norm_div_if.slave bus
);
    localparam int CW = $clog2(QW);
    state_t        state;
    logic [BW-1:0] r, bq, r_nx;
    logic [QW-1:0] q;
    logic [CW-1:0] cnt;
    logic          qb;
    logic [AW:0]   n, d;
    // Adding b/2 before the divide turns truncation into round-half-up.
    assign n = {1'b0, bus.a} + (AW+1)'(bus.b >> 1);
    assign d = (AW+1)'({bus.b, {QW{1'b0}}});
    div_step #(.BW(BW)) u_step (.r(r), .din(q[QW-1]), .b(bq), .r_nx(r_nx), .qb(qb));
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.pix      <= '0;
            bus.sat      <= 1'b0;
            bus.div_zero <= 1'b0;
            r            <= '0;
            q            <= '0;
            bq           <= '0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    bq           <= bus.b;
                    bus.in_ready <= 1'b0;
                    if (bus.b == '0) begin
                        bus.pix       <= '0;
                        bus.div_zero  <= 1'b1;
                        bus.sat       <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else if (n >= d) begin
                        bus.pix       <= QW'(PIX_MAX);
                        bus.sat       <= 1'b1;
                        bus.div_zero  <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        // N < D guarantees the upper part of N is already below b.
                        r     <= n[QW+BW-1:QW];
                        q     <= n[QW-1:0];
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    r   <= r_nx;
                    q   <= {q[QW-2:0], qb};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(QW-1)) begin
                        bus.pix       <= {q[QW-2:0], qb};
                        bus.sat       <= 1'b0;
                        bus.div_zero  <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
